// File: rtl/hazard_md_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_md_ctrl
//   Stall controller and mult/div sequencer for the 5-stage MIPS pipeline.
//   Decodes the instructions in D, E and M and compares when D needs each
//   source (Tuse) with when the producer in E or M will have its result
//   (Tnew). A hazard that forwarding cannot cover stalls F/D and bubbles E.
//   It also starts the multi-cycle HI/LO unit when a MULT/MULTU/DIV/DIVU
//   reaches E, and holds any HI/LO-class instruction in D while that unit
//   is busy.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-low reset (clears the busy counter)
//   InstrD    in   [31:0] instruction in Decode
//   InstrE    in   [31:0] instruction in Execute
//   InstrM    in   [31:0] instruction in Memory
//   StallF    out  hold PC
//   StallD    out  hold F/D register
//   FlushE    out  clear D/E register (insert nop)
//   md_start  out  one-cycle start pulse to the mult/div unit
//   md_op     out  [1:0] 0 MULT, 1 MULTU, 2 DIV, 3 DIVU (0 when idle)
//   md_busy   out  HI/LO unit occupied
// -----------------------------------------------------------------------------
module hazard_md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [31:0] InstrE,
    input  logic [31:0] InstrM,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic        md_start,
    output logic [1:0]  md_op,
    output logic        md_busy
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    // D stage: which sources are read and how soon they are needed
    logic       w_d_rs_used, w_d_rt_used, w_d_md_class;
    logic [1:0] w_d_rs_tuse, w_d_rt_tuse;
    // E/M stage: destination register and cycles until its value exists
    logic [4:0] w_e_dst, w_m_dst;
    logic [1:0] w_e_tnew, w_m_tnew;
    logic       w_e_is_div;
    logic       w_gpr_stall, w_md_stall, w_stall;
    logic       w_unused;

    logic [CNT_W-1:0] r_cnt;

    // Fields the decode never looks at (shamt, unused register slots).
    assign w_unused = ^{InstrD[15:6], InstrE[25:21], InstrE[10:6],
                        InstrM[25:21], InstrM[15:0]};

    always_comb begin
        w_d_rs_used  = 1'b0;
        w_d_rs_tuse  = 2'd0;
        w_d_rt_used  = 1'b0;
        w_d_rt_tuse  = 2'd0;
        w_d_md_class = 1'b0;
        if (InstrD[31:26] == OP_RTYPE) begin
            case (InstrD[5:0])
                FN_ADDU, FN_SUBU: begin
                    w_d_rs_used = 1'b1; w_d_rs_tuse = 2'd1;
                    w_d_rt_used = 1'b1; w_d_rt_tuse = 2'd1;
                end
                FN_JR: begin
                    w_d_rs_used = 1'b1; w_d_rs_tuse = 2'd0;
                end
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                    w_d_rs_used = 1'b1; w_d_rs_tuse = 2'd1;
                    w_d_rt_used = 1'b1; w_d_rt_tuse = 2'd1;
                    w_d_md_class = 1'b1;
                end
                FN_MTHI, FN_MTLO: begin
                    w_d_rs_used = 1'b1; w_d_rs_tuse = 2'd1;
                    w_d_md_class = 1'b1;
                end
                FN_MFHI, FN_MFLO: w_d_md_class = 1'b1;
                default: ;
            endcase
        end else begin
            case (InstrD[31:26])
                OP_ORI, OP_LW: begin
                    w_d_rs_used = 1'b1; w_d_rs_tuse = 2'd1;
                end
                OP_SW: begin
                    // Store data is only needed in M, so rt tolerates a load in E.
                    w_d_rs_used = 1'b1; w_d_rs_tuse = 2'd1;
                    w_d_rt_used = 1'b1; w_d_rt_tuse = 2'd2;
                end
                OP_BEQ: begin
                    w_d_rs_used = 1'b1; w_d_rs_tuse = 2'd0;
                    w_d_rt_used = 1'b1; w_d_rt_tuse = 2'd0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_e_dst    = 5'd0;
        w_e_tnew   = 2'd0;
        md_start   = 1'b0;
        w_e_is_div = 1'b0;
        if (InstrE[31:26] == OP_RTYPE) begin
            case (InstrE[5:0])
                FN_ADDU, FN_SUBU, FN_MFHI, FN_MFLO: begin
                    w_e_dst = InstrE[15:11]; w_e_tnew = 2'd1;
                end
                FN_MULT, FN_MULTU: md_start = 1'b1;
                FN_DIV, FN_DIVU: begin
                    md_start = 1'b1; w_e_is_div = 1'b1;
                end
                default: ;
            endcase
        end else begin
            case (InstrE[31:26])
                OP_LW: begin
                    w_e_dst = InstrE[20:16]; w_e_tnew = 2'd2;
                end
                OP_ORI, OP_LUI: begin
                    w_e_dst = InstrE[20:16]; w_e_tnew = 2'd1;
                end
                // Link value is produced in E already, so it never stalls.
                OP_JAL: begin
                    w_e_dst = 5'd31; w_e_tnew = 2'd0;
                end
                default: ;
            endcase
        end
    end

    // In M only a load still has a result outstanding.
    assign w_m_dst  = (InstrM[31:26] == OP_LW) ? InstrM[20:16] : 5'd0;
    assign w_m_tnew = (InstrM[31:26] == OP_LW) ? 2'd1 : 2'd0;

    function automatic logic src_hazard(input logic       used,
                                        input logic [4:0] src,
                                        input logic [1:0] tuse,
                                        input logic [4:0] e_dst,
                                        input logic [1:0] e_tnew,
                                        input logic [4:0] m_dst,
                                        input logic [1:0] m_tnew);
        logic hit_e, hit_m;
        hit_e = (src == e_dst) && (e_tnew > tuse);
        hit_m = (src == m_dst) && (m_tnew > tuse);
        return used && (src != 5'd0) && (hit_e || hit_m);
    endfunction

    assign w_gpr_stall =
        src_hazard(w_d_rs_used, InstrD[25:21], w_d_rs_tuse,
                   w_e_dst, w_e_tnew, w_m_dst, w_m_tnew) |
        src_hazard(w_d_rt_used, InstrD[20:16], w_d_rt_tuse,
                   w_e_dst, w_e_tnew, w_m_dst, w_m_tnew);

    // Busy counter: a start reloads even mid-operation (latest wins);
    // reset aborts whatever is in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (md_start) begin
            r_cnt <= w_e_is_div ? DIV_LOAD : MULT_LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign md_op      = md_start ? InstrE[1:0] : 2'b00;
    assign md_busy    = md_start | (r_cnt != '0);
    assign w_md_stall = md_busy & w_d_md_class;
    assign w_stall    = w_gpr_stall | w_md_stall;

    assign StallF = w_stall;
    assign StallD = w_stall;
    assign FlushE = w_stall;

endmodule

// File: tb/tb_hazard_md_ctrl.sv
module tb_hazard_md_ctrl;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] InstrD = '0, InstrE = '0, InstrM = '0;
    logic        StallF, StallD, FlushE, md_start, md_busy;
    logic [1:0]  md_op;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int busy_until = -100;

    hazard_md_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .InstrD(InstrD), .InstrE(InstrE), .InstrM(InstrM),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .md_start(md_start), .md_op(md_op), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef enum int {
        K_NOP, K_ADDU, K_SUBU, K_JR, K_MULT, K_MULTU, K_DIV, K_DIVU,
        K_MFHI, K_MFLO, K_MTHI, K_MTLO, K_ORI, K_LUI, K_LW, K_SW,
        K_BEQ, K_J, K_JAL
    } kind_t;

    // ---------------- encoders ----------------
    function automatic logic [31:0] rt_i(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction
    function automatic logic [31:0] it_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // ---------------- reference model ----------------
    function automatic kind_t kind_of(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'd0) begin
            case (fn)
                6'b100001: return K_ADDU;
                6'b100011: return K_SUBU;
                6'b001000: return K_JR;
                6'b011000: return K_MULT;
                6'b011001: return K_MULTU;
                6'b011010: return K_DIV;
                6'b011011: return K_DIVU;
                6'b010000: return K_MFHI;
                6'b010010: return K_MFLO;
                6'b010001: return K_MTHI;
                6'b010011: return K_MTLO;
                default:   return K_NOP;
            endcase
        end
        case (op)
            6'b001101: return K_ORI;
            6'b001111: return K_LUI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            default:   return K_NOP;
        endcase
    endfunction

    function automatic bit is_md_start(input kind_t k);
        return k inside {K_MULT, K_MULTU, K_DIV, K_DIVU};
    endfunction
    function automatic bit is_md_class(input kind_t k);
        return k inside {K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO, K_MTHI, K_MTLO};
    endfunction
    // -1 means the source is not read
    function automatic int tuse_rs(input kind_t k);
        if (k inside {K_BEQ, K_JR}) return 0;
        if (k inside {K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_MULT, K_MULTU,
                      K_DIV, K_DIVU, K_MTHI, K_MTLO}) return 1;
        return -1;
    endfunction
    function automatic int tuse_rt(input kind_t k);
        if (k == K_BEQ) return 0;
        if (k inside {K_ADDU, K_SUBU, K_MULT, K_MULTU, K_DIV, K_DIVU}) return 1;
        if (k == K_SW) return 2;
        return -1;
    endfunction

    function automatic bit model_gpr(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
        kind_t kd, ke;
        int srcs[2], tus[2];
        int de, te, dm, tm;
        bit st;
        kd = kind_of(d);
        ke = kind_of(e);
        srcs[0] = int'(d[25:21]); tus[0] = tuse_rs(kd);
        srcs[1] = int'(d[20:16]); tus[1] = tuse_rt(kd);
        de = 0; te = 0;
        case (ke)
            K_LW:                         begin de = int'(e[20:16]); te = 2; end
            K_ADDU, K_SUBU, K_MFHI, K_MFLO: begin de = int'(e[15:11]); te = 1; end
            K_ORI, K_LUI:                 begin de = int'(e[20:16]); te = 1; end
            K_JAL:                        begin de = 31; te = 0; end
            default: ;
        endcase
        dm = 0; tm = 0;
        if (kind_of(m) == K_LW) begin dm = int'(m[20:16]); tm = 1; end
        st = 0;
        for (int i = 0; i < 2; i++) begin
            if (tus[i] >= 0 && srcs[i] != 0) begin
                if (srcs[i] == de && te > tus[i]) st = 1;
                if (srcs[i] == dm && tm > tus[i]) st = 1;
            end
        end
        return st;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive, compare against model (and optional
    // directed expectations, -1 = don't care), then advance the model.
    task automatic step(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                        input logic rst_n, input int x_stall, input int x_busy, input int x_sop);
        kind_t ke;
        bit start, busy, stall;
        logic [1:0] op;
        @(negedge clk);
        InstrD = d; InstrE = e; InstrM = m; reset = rst_n;
        #1;
        ke    = kind_of(e);
        start = is_md_start(ke);
        case (ke)
            K_MULTU: op = 2'd1;
            K_DIV:   op = 2'd2;
            K_DIVU:  op = 2'd3;
            default: op = 2'd0;
        endcase
        busy  = start || (cyc <= busy_until);
        stall = model_gpr(d, e, m) || (busy && is_md_class(kind_of(d)));
        check("stall_vec", {29'd0, StallF, StallD, FlushE}, {29'd0, {3{stall}}});
        check("md_vec", {28'd0, md_start, md_op, md_busy}, {28'd0, start, op, busy});
        if (x_stall >= 0) check("dir_stall", {31'd0, StallF}, 32'(x_stall));
        if (x_busy >= 0)  check("dir_busy", {31'd0, md_busy}, 32'(x_busy));
        if (x_sop >= 0)   check("dir_start_op", {29'd0, md_start, md_op}, 32'(x_sop));
        @(posedge clk);
        if (!rst_n)     busy_until = -100;
        else if (start) busy_until = cyc + ((ke inside {K_DIV, K_DIVU}) ? DIV_CYCLES : MULT_CYCLES);
        cyc++;
    endtask

    function automatic logic [31:0] rand_instr();
        int r1, r2, r3;
        r1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3));
        r2 = int'($urandom_range(0, 3));
        r3 = int'($urandom_range(0, 3));
        case ($urandom_range(0, 19))
            0:  return rt_i(r1, r2, r3, 6'b100001);
            1:  return rt_i(r1, r2, r3, 6'b100011);
            2:  return rt_i(r1, 0, 0, 6'b001000);
            3:  return rt_i(r1, r2, 0, 6'b011000);
            4:  return rt_i(r1, r2, 0, 6'b011001);
            5:  return rt_i(r1, r2, 0, 6'b011010);
            6:  return rt_i(r1, r2, 0, 6'b011011);
            7:  return rt_i(0, 0, r3, 6'b010000);
            8:  return rt_i(0, 0, r3, 6'b010010);
            9:  return rt_i(r1, 0, 0, 6'b010001);
            10: return rt_i(r1, 0, 0, 6'b010011);
            11: return it_i(6'b001101, r1, r2, 7);
            12: return it_i(6'b001111, 0, r2, 1);
            13: return it_i(6'b100011, r1, r2, 4);
            14: return it_i(6'b101011, r1, r2, 8);
            15: return it_i(6'b000100, r1, r2, 2);
            16: return {6'b000010, 26'h12};
            17: return {6'b000011, 26'h34};
            18: return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    localparam logic [31:0] NOP = 32'd0;

    initial begin
        logic [31:0] mflo, mfhi, addu123, sw34;

        // reset with nops: everything quiet
        for (int i = 0; i < 3; i++) step(NOP, NOP, NOP, 1'b0, 0, 0, 0);
        step(NOP, NOP, NOP, 1'b1, 0, 0, 0);

        // load-use
        step(rt_i(8, 1, 9, 6'b100001), it_i(6'b100011, 0, 8, 0), NOP, 1'b1, 1, 0, 0);
        step(rt_i(8, 1, 9, 6'b100001), NOP, it_i(6'b100011, 0, 8, 0), 1'b1, 0, 0, 0);

        // branch after ALU op, and same with $0 destination
        step(it_i(6'b000100, 5, 0, 0), it_i(6'b001101, 0, 5, 1), NOP, 1'b1, 1, 0, 0);
        step(it_i(6'b000100, 5, 0, 0), NOP, it_i(6'b001101, 0, 5, 1), 1'b1, 0, 0, 0);
        step(it_i(6'b000100, 0, 0, 0), it_i(6'b001101, 0, 0, 1), NOP, 1'b1, 0, 0, 0);

        // store after load
        sw34 = it_i(6'b101011, 4, 3, 0);
        step(sw34, it_i(6'b100011, 0, 3, 0), NOP, 1'b1, 0, 0, 0);
        step(sw34, it_i(6'b100011, 0, 4, 0), NOP, 1'b1, 1, 0, 0);

        // MULT then MFLO: 6 stall cycles
        mflo = rt_i(0, 0, 4, 6'b010010);
        step(mflo, rt_i(1, 2, 0, 6'b011000), NOP, 1'b1, 1, 1, 3'b100);
        for (int i = 0; i < MULT_CYCLES; i++) step(mflo, NOP, NOP, 1'b1, 1, 1, 0);
        step(mflo, NOP, NOP, 1'b1, 0, 0, 0);

        // DIVU then MFLO: 11 stall cycles
        step(mflo, rt_i(1, 2, 0, 6'b011011), NOP, 1'b1, 1, 1, 3'b111);
        for (int i = 0; i < DIV_CYCLES; i++) step(mflo, NOP, NOP, 1'b1, 1, 1, 0);
        step(mflo, NOP, NOP, 1'b1, 0, 0, 0);

        // reset while a DIV is counting (counter at 7 in the 5th cycle)
        mfhi = rt_i(0, 0, 6, 6'b010000);
        step(mfhi, rt_i(3, 2, 0, 6'b011010), NOP, 1'b1, 1, 1, 3'b110);
        for (int i = 0; i < 3; i++) step(mfhi, NOP, NOP, 1'b1, 1, 1, 0);
        step(mfhi, NOP, NOP, 1'b0, 1, 1, 0);
        step(mfhi, NOP, NOP, 1'b1, 0, 0, 0);

        // non-md instruction in D while busy
        addu123 = rt_i(2, 3, 1, 6'b100001);
        step(NOP, rt_i(1, 2, 0, 6'b011000), NOP, 1'b1, 0, 1, 3'b100);
        for (int i = 0; i < 3; i++) step(addu123, NOP, NOP, 1'b1, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(NOP, NOP, NOP, 1'b1, 0, -1, 0);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            step(rand_instr(), ($urandom_range(0, 3) == 0) ? NOP : rand_instr(),
                 rand_instr(), ($urandom_range(0, 60) == 0) ? 1'b0 : 1'b1, -1, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_md_ctrl.md
Name: hazard_md_ctrl

Overview:
- Pipeline stall controller and mult/div sequencer for the 5-stage MIPS core.
- Sits beside the forwarding unit.
- Decodes D/E/M instructions and applies Tuse/Tnew rules to stall F/D and bubble E on GPR hazards that forwarding cannot cover.
- Issues start pulses to the multi-cycle HI/LO unit and stalls any HI/LO-class instruction in D while that unit is busy.

Parameters:
- MULT_CYCLES, 5, busy cycles after start for MULT/MULTU.
- DIV_CYCLES, 10, busy cycles after start for DIV/DIVU.
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- InstrD  in  32  instruction in Decode.
- InstrE  in  32  instruction in Execute.
- InstrM  in  32  instruction in Memory.
- StallF  out  1  hold PC.
- StallD  out  1  hold F/D register.
- FlushE  out  1  clear D/E register (insert nop).
- md_start  out  1  one-cycle start to mult/div unit.
- md_op  out  2  0 MULT, 1 MULTU, 2 DIV, 3 DIVU; valid when md_start=1.
- md_busy  out  1  HI/LO unit occupied.

Behaviour:
- Decode, R-type funct: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MFLO 010010, MTHI 010001, MTLO 010011, plus ADDU, SUBU, JR.
- Decode, opcode: ORI, LUI, LW, SW, BEQ, J, JAL.
- Any unlisted encoding is treated as a nop: no source, no destination, not md-class.
- md-class instructions: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- Tuse (D sources):
  - BEQ rs,rt = 0; JR rs = 0.
  - ADDU/SUBU rs,rt = 1; ORI/LW rs = 1; SW rs = 1; SW rt = 2.
  - MULT/MULTU/DIV/DIVU rs,rt = 1; MTHI/MTLO rs = 1.
- Tnew in E, with destination register:
  - LW = 2 (rt).
  - ADDU/SUBU (rd), ORI/LUI (rt), MFHI/MFLO (rd) = 1.
  - JAL = 0 (reg 31).
- Tnew in M: LW = 1; all others 0.
- gpr_stall = 1 when some D source with Tuse matches a nonzero E or M destination with Tnew > Tuse. Register 0 never matches.
- Counter cnt (CNT_W bits):
  - On reset=0 at a clock edge: cnt <= 0, regardless of current value (aborts an in-flight operation).
  - md_start = 1 (combinational) iff InstrE is MULT/MULTU/DIV/DIVU.
  - md_op is taken from the InstrE funct low bits; it is 0 when md_start=0.
  - Edge with md_start=1: cnt <= MULT_CYCLES or DIV_CYCLES. A start while cnt != 0 reloads (latest wins). This condition is normally unreachable.
  - Otherwise, if cnt != 0: cnt <= cnt - 1. No wrap below 0.
- md_busy = md_start | (cnt != 0).
  - For a MULT that is in E at cycle t: busy during t .. t+MULT_CYCLES, i.e. MULT_CYCLES+1 cycles.
- md_stall = md_busy & (InstrD is md-class).
- Stall outputs: StallF = StallD = FlushE = gpr_stall | md_stall. They are purely combinational from inputs and cnt, with no extra latency.
- Reset values: cnt = 0. With nop inputs (all-zero instructions), every output is 0.
- During a stall, E/M continue advancing, so the counter keeps counting down. An md instruction cannot enter E while busy unless stimulus is forced.

Test Plan:
- Load-use: E=LW $8,0($0), D=ADDU $9,$8,$1 → stall=1 for 1 cycle. Next cycle E=nop, M=LW, D held → stall=0.
- Branch after ALU: E=ORI $5,$0,1, D=BEQ $5,$0 → stall=1. Next cycle M=ORI → stall=0. Same case with dest $0 → stall=0.
- SW after LW: E=LW $3, D=SW $3,0($4) → stall=0 (Tuse 2 ≥ Tnew 2). E=LW $4, same SW → stall=1.
- MULT then MFLO: MULT in E at t → md_start=1, md_op=0. D=MFLO held, stall=1 for cycles t..t+5 (6 cycles), released at t+6 with cnt=0. Repeat with DIVU: md_op=3, stall 11 cycles.
- Reset mid-op: DIV started, drive reset=0 at cnt=7 → next cycle cnt=0, md_busy=0, stall=0 with MFHI in D.
- Non-md instruction in D while busy: D=ADDU $1,$2,$3 during MULT countdown → stall=0, md_busy stays 1.
